uart_tx_reporter: RTL and testbench

//   UART transmitter that returns data from the board to the host PC. It is the

---
 rtl/uart_tx_reporter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_reporter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_reporter.sv
// uart_tx_reporter: 8N1 UART transmitter fed by a small byte FIFO.
// Ports: i_clk, i_rst (sync, active-high); push side i_data/i_wide/i_valid
// with o_ready; o_tx serial line (idle high, registered); o_busy activity.
module uart_tx_reporter #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_data,
    input  logic        i_wide,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_tx,
    output logic        o_busy
);
    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CW  = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNW = AW + 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CNW-1:0] DEPTH     = CNW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [CNW-1:0] cnt_q;
    logic [CNW-1:0] cnt_d;
    logic [CNW-1:0] free;
    state_e         state_q;
    logic [CW-1:0]  baud_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic           push;
    logic           pop;
    logic           baud_end;

    // Ready looks only at the registered fill level, never at a same-cycle pop.
    assign free     = DEPTH - cnt_q;
    assign o_ready  = i_wide ? (free >= CNW'(2)) : (free != '0);
    assign push     = i_valid && o_ready;
    assign baud_end = (baud_q == BAUD_LAST);
    // Pop from IDLE, or on the last stop cycle to chain frames with no gap.
    assign pop      = (cnt_q != '0) &&
                      ((state_q == IDLE) || ((state_q == STOP) && baud_end));

    assign o_tx   = tx_q;
    assign o_busy = (state_q != IDLE) || (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (push) begin
            cnt_d = cnt_d + (i_wide ? CNW'(2) : CNW'(1));
        end
        if (pop) begin
            cnt_d = cnt_d - CNW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push) begin
                wr_q <= wr_q + (i_wide ? AW'(2) : AW'(1));
            end
        end
    end

    // Wide pushes land high byte first so the line order is [15:8], [7:0].
    always_ff @(posedge i_clk) begin
        if (push) begin
            if (i_wide) begin
                mem_q[wr_q]          <= i_data[15:8];
                mem_q[wr_q + AW'(1)] <= i_data[7:0];
            end else begin
                mem_q[wr_q] <= i_data[7:0];
            end
        end
    end

    // o_tx is registered from the current state, so the line lags the
    // state by one cycle; every bit still lasts exactly BIT_CYCLES.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_q];
                        state_q <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (baud_end) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rd_q];
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_reporter.sv
// tb_uart_tx_reporter: directed bench for uart_tx_reporter.
// Default-rate instance for one full frame, BIT_CYCLES=10 instance for the rest.
module tb_uart_tx_reporter;
    logic        clk = 1'b0;
    logic        rst_d, wide_d, valid_d, ready_d, tx_d, busy_d;
    logic [15:0] data_d;
    logic        rst_s, wide_s, valid_s, ready_s, tx_s, busy_s;
    logic [15:0] data_s;

    int checks = 0;
    int fails  = 0;

    int rxq[$];
    logic       mon_act  = 1'b0;
    int         mon_cnt  = 0;
    logic [7:0] mon_sh   = 8'h00;
    logic       rst_seen = 1'b1;

    int e3[5] = '{8'hE0, 8'h00, 8'hC1, 8'h80, 8'h5A};
    int e4[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    always #5 clk = ~clk;

    uart_tx_reporter dut (
        .i_clk(clk), .i_rst(rst_d), .i_data(data_d), .i_wide(wide_d),
        .i_valid(valid_d), .o_ready(ready_d), .o_tx(tx_d), .o_busy(busy_d)
    );

    uart_tx_reporter #(.CLK_FREQ(10), .BAUD_RATE(1), .FIFO_DEPTH(4)) dut_s (
        .i_clk(clk), .i_rst(rst_s), .i_data(data_s), .i_wide(wide_s),
        .i_valid(valid_s), .o_ready(ready_s), .o_tx(tx_s), .o_busy(busy_s)
    );

    // Line receiver for the BIT_CYCLES=10 instance: samples mid-bit.
    always @(posedge clk) rst_seen <= rst_s;

    always @(negedge clk) begin
        if (rst_seen) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (tx_s === 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt == 5 && tx_s !== 1'b0) mon_act <= 1'b0;
            if (mon_cnt >= 15 && mon_cnt <= 85 && mon_cnt % 10 == 5)
                mon_sh <= {tx_s, mon_sh[7:1]};
            if (mon_cnt == 95) begin
                mon_act <= 1'b0;
                rxq.push_back(tx_s === 1'b1 ? int'(mon_sh) : 256 + int'(mon_sh));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_s(input logic [15:0] d, input logic w);
        data_s  = d;
        wide_s  = w;
        valid_s = 1'b1;
        @(negedge clk);
        valid_s = 1'b0;
        wide_s  = 1'b0;
    endtask

    // Expects the next posedge to register the start bit.
    task automatic frame(input logic sm, input logic [7:0] b, input int bc,
                         input string tag);
        logic [9:0] bits;
        int good;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            good = 0;
            repeat (bc) begin
                @(negedge clk);
                if ((sm ? tx_s : tx_d) === bits[k]) good++;
            end
            chk($sformatf("%s bit%0d cycles", tag, k), good, bc);
        end
    endtask

    task automatic wait_rx(input int n, input int lim, input string tag);
        for (int i = 0; i < lim && rxq.size() < n; i++) @(negedge clk);
        chk({tag, " rx count"}, rxq.size(), n);
    endtask

    task automatic wait_idle(input int lim, input string tag);
        for (int i = 0; i < lim && busy_s !== 1'b0; i++) @(negedge clk);
        chk({tag, " idle"}, busy_s, 1'b0);
    endtask

    task automatic rx_item(input int i, input int exp, input string tag);
        chk($sformatf("%s byte%0d", tag, i), (i < rxq.size()) ? rxq[i] : -1, exp);
    endtask

    initial begin
        rst_d = 1'b1; data_d = '0; wide_d = 1'b0; valid_d = 1'b0;
        rst_s = 1'b1; data_s = '0; wide_s = 1'b0; valid_s = 1'b0;
        repeat (3) @(negedge clk);
        rst_d = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);
        chk("reset tx", tx_d, 1'b1);
        chk("reset busy", busy_d, 1'b0);
        chk("reset ready", ready_d, 1'b1);
        chk("reset tx small", tx_s, 1'b1);
        chk("reset busy small", busy_s, 1'b0);

        // Byte 0x41 at 868 cycles per bit.
        data_d = 16'h0041; valid_d = 1'b1;
        @(negedge clk);
        valid_d = 1'b0;
        chk("t1 busy after push", busy_d, 1'b1);
        chk("t1 tx at N+1", tx_d, 1'b1);
        @(negedge clk);
        chk("t1 tx at N+1 pop", tx_d, 1'b1);
        frame(1'b0, 8'h41, 868, "t1");
        chk("t1 busy end", busy_d, 1'b0);
        @(negedge clk);
        chk("t1 tx idle", tx_d, 1'b1);

        // 0xFF with BIT_CYCLES=10.
        push_s(16'h00FF, 1'b0);
        @(negedge clk);
        frame(1'b1, 8'hFF, 10, "t6");
        chk("t6 busy end", busy_s, 1'b0);

        // Wide word: two frames, no gap.
        push_s(16'h4126, 1'b1);
        @(negedge clk);
        frame(1'b1, 8'h41, 10, "t2 hi");
        frame(1'b1, 8'h26, 10, "t2 lo");
        chk("t2 busy end", busy_s, 1'b0);
        chk("rx count so far", rxq.size(), 3);
        rx_item(0, 8'hFF, "rx");
        rx_item(1, 8'h41, "rx");
        rx_item(2, 8'h26, "rx");

        // Fill the FIFO.
        rxq.delete();
        push_s(16'h00E0, 1'b0);
        push_s(16'h0000, 1'b0);
        push_s(16'h00C1, 1'b0);
        push_s(16'h0080, 1'b0);
        chk("t3 ready byte 1 free", ready_s, 1'b1);
        wide_s = 1'b1;
        #1;
        chk("t3 ready wide 1 free", ready_s, 1'b0);
        wide_s = 1'b0;
        push_s(16'h005A, 1'b0);
        chk("t3 ready full", ready_s, 1'b0);
        data_s = 16'h0099; valid_s = 1'b1;
        @(negedge clk);
        valid_s = 1'b0;
        chk("t3 busy", busy_s, 1'b1);
        wait_rx(5, 800, "t3");
        wait_idle(300, "t3");
        chk("t3 final count", rxq.size(), 5);
        for (int i = 0; i < 5; i++) rx_item(i, e3[i], "t3");

        // Push on the STOP-end pop edge.
        rxq.delete();
        push_s(16'h1122, 1'b1);
        push_s(16'h3344, 1'b1);
        repeat (99) @(negedge clk);
        data_s = 16'h0055; wide_s = 1'b0; valid_s = 1'b1;
        #1;
        chk("t4 ready before pop", ready_s, 1'b1);
        @(negedge clk);
        valid_s = 1'b0;
        chk("t4 ready after push+pop", ready_s, 1'b1);
        wide_s = 1'b1;
        #1;
        chk("t4 wide after push+pop", ready_s, 1'b0);
        wide_s = 1'b0;
        push_s(16'h0066, 1'b0);
        chk("t4 ready full", ready_s, 1'b0);
        repeat (98) @(negedge clk);
        data_s = 16'h0077; valid_s = 1'b1;
        #1;
        chk("t4 ready full at pop", ready_s, 1'b0);
        @(negedge clk);
        valid_s = 1'b0;
        chk("t4 ready after pop", ready_s, 1'b1);
        wait_rx(6, 900, "t4");
        wait_idle(300, "t4");
        chk("t4 final count", rxq.size(), 6);
        for (int i = 0; i < 6; i++) rx_item(i, e4[i], "t4");

        // Reset during DATA bit 3 of 0xA5.
        rxq.delete();
        push_s(16'h00A5, 1'b0);
        push_s(16'h0011, 1'b0);
        repeat (43) @(negedge clk);
        chk("t5 tx bit3 low", tx_s, 1'b0);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        chk("t5 tx after reset", tx_s, 1'b1);
        chk("t5 busy after reset", busy_s, 1'b0);
        wide_s = 1'b1;
        #1;
        chk("t5 ready wide empty", ready_s, 1'b1);
        wide_s = 1'b0;
        repeat (150) @(negedge clk);
        chk("t5 no stray frame", rxq.size(), 0);
        chk("t5 still idle", busy_s, 1'b0);
        push_s(16'h003C, 1'b0);
        wait_rx(1, 200, "t5");
        wait_idle(200, "t5");
        chk("t5 final count", rxq.size(), 1);
        rx_item(0, 8'h3C, "t5");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
